res_packer: RTL and testbench

RES_PACKER -- requirements
Module: res_packer

---
 rtl/res_packer.sv | 145 ++++++++++++++
 tb/tb_res_packer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/res_packer.sv
// res_packer
//   Reads a 128x128 byte image out of the result RAM (one pixel per cycle),
//   thresholds each pixel to one bit and packs 16 pixels per word into the
//   packed-word RAM, with the leftmost pixel in bit 15.
//
//   Optional feature macro: PACK_CRC_EN
//     defined   -> crc carries a running CRC-16-CCITT (poly 0x1021, init
//                  0xFFFF, MSB first, no final XOR) of every word written
//     undefined -> crc is tied to 16'h0000
//
// Ports
//   clk       clock, all state changes on the rising edge
//   reset     synchronous active-high reset
//   start     run request, only honoured in IDLE
//   res_rd    result-RAM read enable
//   res_addr  result-RAM pixel address (0..16383)
//   res_di    result-RAM read data, valid at the edge after the address cycle
//   sti_wr    packed-word write strobe (one cycle per word)
//   sti_addr  packed-word address (0..1023)
//   sti_do    packed word
//   busy      run in progress
//   done      one-cycle pulse after the last word is written
//   crc       running CRC of the packed words (see macro above)
module res_packer #(
    parameter logic [7:0] THRESH = 8'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        res_rd,
    output logic [13:0] res_addr,
    input  logic [7:0]  res_di,
    output logic        sti_wr,
    output logic [9:0]  sti_addr,
    output logic [15:0] sti_do,
    output logic        busy,
    output logic        done,
    output logic [15:0] crc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Unsigned compare: with THRESH = 8'hFF nothing can exceed it.
    function automatic logic pack_bit(input logic [7:0] px);
        return (px > THRESH);
    endfunction

    logic        pix_p0;
    logic        wend_p0;
    logic [14:0] shift_p1;
    logic [15:0] word_p0;

    // res_rd is the registered read decision, so during the cycle of edge
    // P(k+1) it still reflects whether address k was read; it acts as the
    // delayed read flag that qualifies res_di.
    assign pix_p0  = pack_bit(res_di);
    assign wend_p0 = res_rd && (res_addr[3:0] == 4'hF);
    assign word_p0 = {shift_p1, pix_p0};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = READ;
            READ:    if (res_addr == 14'h3FFF) state_d = FLUSH;
            FLUSH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == READ) || (state_q == FLUSH);
    assign done = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            res_rd   <= 1'b0;
            res_addr <= 14'd0;
            shift_p1 <= 15'd0;
            sti_wr   <= 1'b0;
            sti_addr <= 10'd0;
            sti_do   <= 16'd0;
        end else begin
            state_q <= state_d;
            res_rd  <= (state_d == READ);
            sti_wr  <= 1'b0;

            // Counter starts at 0 on acceptance and wraps to 0 leaving READ.
            if ((state_q == READ) && (state_d == READ))
                res_addr <= res_addr + 14'd1;
            else
                res_addr <= 14'd0;

            // ---- capture stage: pixel k arrives at P(k+1) ----
            if (res_rd) begin
                shift_p1 <= word_p0[14:0];
                if (wend_p0) begin
                    sti_wr   <= 1'b1;
                    sti_do   <= word_p0;
                    sti_addr <= res_addr[13:4];
                end
            end
        end
    end

`ifdef PACK_CRC_EN
    function automatic logic [15:0] crc16_word(input logic [15:0] c_in,
                                               input logic [15:0] d);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    logic [15:0] crc_q;

    // Updated on the same edge that registers the word, so crc already
    // includes a word during its sti_wr cycle.
    always_ff @(posedge clk) begin
        if (reset)
            crc_q <= 16'h0000;
        else if ((state_q == IDLE) && start)
            crc_q <= 16'hFFFF;
        else if (wend_p0)
            crc_q <= crc16_word(crc_q, word_p0);
    end

    assign crc = crc_q;
`else
    assign crc = 16'h0000;
`endif

endmodule

// File: tb/tb_res_packer.sv
module tb_res_packer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  res_rd_v;
    logic [13:0] res_addr_v [3];
    logic [7:0]  res_di_v   [3];
    logic [2:0]  sti_wr_v;
    logic [9:0]  sti_addr_v [3];
    logic [15:0] sti_do_v   [3];
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [15:0] crc_v      [3];

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem   [16384];
    logic [15:0] exp_w [3][1024];
    logic [15:0] crc_m [3];
    int          wcnt  [3];
    logic [7:0]  th    [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    res_packer #(.THRESH(8'd0)) dut0 (
        .clk(clk), .reset(reset), .start(start),
        .res_rd(res_rd_v[0]), .res_addr(res_addr_v[0]), .res_di(res_di_v[0]),
        .sti_wr(sti_wr_v[0]), .sti_addr(sti_addr_v[0]), .sti_do(sti_do_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .crc(crc_v[0]));

    res_packer #(.THRESH(8'd4)) dut1 (
        .clk(clk), .reset(reset), .start(start),
        .res_rd(res_rd_v[1]), .res_addr(res_addr_v[1]), .res_di(res_di_v[1]),
        .sti_wr(sti_wr_v[1]), .sti_addr(sti_addr_v[1]), .sti_do(sti_do_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .crc(crc_v[1]));

    res_packer #(.THRESH(8'd5)) dut2 (
        .clk(clk), .reset(reset), .start(start),
        .res_rd(res_rd_v[2]), .res_addr(res_addr_v[2]), .res_di(res_di_v[2]),
        .sti_wr(sti_wr_v[2]), .sti_addr(sti_addr_v[2]), .sti_do(sti_do_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .crc(crc_v[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [15:0] crc_bits(input logic [15:0] c_in,
                                             input logic [15:0] d, input int n);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int i = n - 1; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    // Expected image for every DUT from the pixel rule; clears write counts.
    task automatic prep_run();
        logic [15:0] w;
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 1024; k++) begin
                w = 16'h0000;
                for (int j = 0; j < 16; j++)
                    w[15-j] = (mem[16*k+j] > th[d]);
                exp_w[d][k] = w;
            end
            wcnt[d] = 0;
`ifdef PACK_CRC_EN
            crc_m[d] = 16'hFFFF;
`else
            crc_m[d] = 16'h0000;
`endif
        end
    endtask

    // RAM model: data for the address presented appears at the falling edge.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++)
            res_di_v[d] = res_rd_v[d] ? mem[res_addr_v[d]] : 8'($urandom);
    end

    // Compare process: every write against the model image and CRC.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
`ifndef PACK_CRC_EN
            chk("crc_tied_zero", 32'(crc_v[d]), 32'h0);
`endif
            if (sti_wr_v[d] === 1'b1) begin
                if (wcnt[d] > 1023) begin
                    chk("extra_write", 32'(wcnt[d]), 32'd1023);
                end else begin
                    chk("sti_addr", 32'(sti_addr_v[d]), 32'(wcnt[d]));
                    chk("sti_do", 32'(sti_do_v[d]), 32'(exp_w[d][wcnt[d]]));
`ifdef PACK_CRC_EN
                    crc_m[d] = crc_bits(crc_m[d], exp_w[d][wcnt[d]], 16);
                    chk("crc_write", 32'(crc_v[d]), 32'(crc_m[d]));
`endif
                end
                wcnt[d]++;
            end
        end
    end

    task automatic wait_done(input int k0, output int k);
        k = k0;
        while (1) begin
            @(posedge clk);
            #1;
            k++;
            if (done_v[0] === 1'b1) break;
            if (k > 20000) begin
                chk("done_timeout", 32'(k), 32'd0);
                break;
            end
        end
    endtask

    task automatic chk_counts(input string name);
        for (int d = 0; d < 3; d++)
            chk(name, 32'(wcnt[d]), 32'd1024);
    endtask

    initial begin
        int k;
        int seen;
        logic [15:0] c;
        logic [7:0]  s [9];
        th[0] = 8'd0; th[1] = 8'd4; th[2] = 8'd5;
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        prep_run();

        // Model pin: standard CRC-16/CCITT-FALSE check value of "123456789".
        s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        c = 16'hFFFF;
        for (int i = 0; i < 9; i++) c = crc_bits(c, {8'h00, s[i]}, 8);
        chk("model_crc_check", 32'(c), 32'h29B1);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_res_rd", 32'(res_rd_v[0]), 32'h0);
        chk("rst_res_addr", 32'(res_addr_v[0]), 32'h0);
        chk("rst_sti_wr", 32'(sti_wr_v[0]), 32'h0);
        chk("rst_sti_addr", 32'(sti_addr_v[0]), 32'h0);
        chk("rst_sti_do", 32'(sti_do_v[0]), 32'h0);
        chk("rst_busy", 32'(busy_v[0]), 32'h0);
        chk("rst_done", 32'(done_v[0]), 32'h0);
        chk("rst_crc", 32'(crc_v[0]), 32'h0);

        // Reset wins over start in the same cycle.
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_prio_busy", 32'(busy_v[0]), 32'h0);
        chk("rst_prio_rd", 32'(res_rd_v[0]), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;

        // Start held high: run A over an all-zero image, run B over 0x01 at
        // every 16th pixel, swapped while the block is between runs.
        prep_run();
        chk("model_zero_word", 32'(exp_w[0][0]), 32'h0000);
        @(negedge clk) start = 1'b1;
        wait_done(0, k);
        chk("done_latency_a", 32'(k), 32'd16386);
        chk("busy_at_done", 32'(busy_v[0]), 32'h0);
        chk_counts("writes_a");
        for (int i = 0; i < 16384; i++) mem[i] = (i % 16 == 0) ? 8'h01 : 8'h00;
        prep_run();
        chk("model_8000", 32'(exp_w[0][7]), 32'h8000);
        wait_done(0, k);
        start = 1'b0;
        chk("done_latency_held", 32'(k), 32'd16387);
        chk_counts("writes_b");
        @(posedge clk);
        #1;
        chk("done_one_cycle", 32'(done_v[0]), 32'h0);
        repeat (5) @(posedge clk);
        #1;
        chk("idle_after_release", 32'(busy_v[0]), 32'h0);

        // All 0x05: THRESH 0 and 4 pack ones, THRESH 5 packs zeros.
        for (int i = 0; i < 16384; i++) mem[i] = 8'h05;
        prep_run();
        chk("model_ffff", 32'(exp_w[1][3]), 32'hFFFF);
        chk("model_eq_thresh", 32'(exp_w[2][3]), 32'h0000);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", 32'(busy_v[0]), 32'h1);
        wait_done(1, k);
        chk("done_latency_c", 32'(k), 32'd16386);
        chk_counts("writes_c");

        // Mixed image, aborted by reset 5000 cycles into READ.
        for (int i = 0; i < 16384; i++) mem[i] = 8'((i * 73) ^ (i >> 5));
        prep_run();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5000) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_sti_wr", 32'(sti_wr_v), 32'h0);
        chk("abort_busy", 32'(busy_v), 32'h0);
        chk("abort_res_rd", 32'(res_rd_v), 32'h0);
        chk("abort_crc", 32'(crc_v[0]), 32'h0);
        @(negedge clk) reset = 1'b0;
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (sti_wr_v != 3'b000 || busy_v != 3'b000) seen++;
        end
        chk("quiet_after_abort", 32'(seen), 32'd0);

        // Restart: single 16'h8000 word then zeros, from pixel 0.
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        mem[0] = 8'h80;
        prep_run();
        chk("model_single", 32'(exp_w[2][0]), 32'h8000);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(1, k);
        chk("done_latency_restart", 32'(k), 32'd16386);
        chk_counts("writes_restart");
        repeat (4) @(posedge clk);
        #1;
        chk("crc_hold_after_done", 32'(crc_v[0]), 32'(crc_m[0]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
